csr_uart_rx_fifo: RTL

// - CSR-bus responder answering the pipeline's CSR initiator port at one address:
//   a buffered 8N1 UART receiver.
// - Deserialises the rx pin into a byte FIFO; the core pops bytes by CSR read.
// - Sits beside the default CSR unit; the top wrapper ORs rdata/valid of all responders.

---
 rtl/csr_uart_rx_fifo_pkg.sv | 41 ++++
 rtl/byte_fifo.sv | 62 ++++++
 rtl/csr_uart_rx_fifo.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/csr_uart_rx_fifo_pkg.sv
// Shared definitions for the buffered UART receiver CSR responder:
// receiver FSM states, CSR status-word layout and modify op codes.
package csr_uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    localparam int CSR_BIT_EMPTY = 31;
    localparam int CSR_BIT_OVR   = 30;
    localparam int CSR_BIT_FERR  = 29;
    localparam int CSR_CNT_LSB   = 16;

    localparam logic [1:0] MOD_NONE  = 2'b00;
    localparam logic [1:0] MOD_WRITE = 2'b01;
    localparam logic [1:0] MOD_SET   = 2'b10;
    localparam logic [1:0] MOD_CLEAR = 2'b11;

    // Head byte reads as zero when the FIFO is empty so stale RAM never leaks out.
    function automatic logic [31:0] pack_status(
        input logic       empty,
        input logic       ovr,
        input logic       ferr,
        input logic [4:0] count,
        input logic [7:0] head
    );
        logic [31:0] w;
        w                      = '0;
        w[CSR_BIT_EMPTY]       = empty;
        w[CSR_BIT_OVR]         = ovr;
        w[CSR_BIT_FERR]        = ferr;
        w[CSR_CNT_LSB +: 5]    = count;
        w[7:0]                 = empty ? 8'h00 : head;
        return w;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through head, occupancy count
// and a drop indication for pushes that find no room.
module byte_fifo #(
    parameter int FIFO_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic [7:0]           i_push_data,
    input  logic                 i_pop,
    output logic [7:0]           o_head,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [FIFO_LOG2:0]   o_count,
    output logic                 o_dropped
);
    localparam int DEPTH = 2 ** FIFO_LOG2;

    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_LOG2-1:0] r_wr_ptr;
    logic [FIFO_LOG2-1:0] r_rd_ptr;
    logic [FIFO_LOG2:0]   r_count;
    logic                 w_pop_ok;
    logic                 w_push_ok;

    assign o_full    = (r_count == (FIFO_LOG2+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_dropped = i_push & ~w_push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + FIFO_LOG2'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + FIFO_LOG2'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (FIFO_LOG2+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_LOG2+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/csr_uart_rx_fifo.sv
// CSR responder for a buffered 8N1 UART receiver: rx synchroniser, bit-timing
// FSM, byte FIFO and a registered single-address CSR response.
module csr_uart_rx_fifo
    import csr_uart_rx_fifo_pkg::*;
#(
    parameter int          CLOCK_RATE = 50_000_000,
    parameter int          BAUD_RATE  = 115200,
    parameter int          FIFO_LOG2  = 4,
    parameter logic [11:0] CSR_ADDR   = 12'hBC3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        rx,
    output logic        irq_rx
);
    localparam int DIV   = CLOCK_RATE / BAUD_RATE;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic               r_rx_meta;
    logic               r_rx_sync;
    rx_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_ovr;
    logic               r_ferr;
    logic [31:0]        r_rdata;
    logic               r_valid;
    logic               r_irq;

    logic               w_stop_tick;
    logic               w_push;
    logic               w_ferr_set;
    logic               w_req;
    logic               w_pop;
    logic               w_clr;
    logic               w_modify;
    logic [7:0]         w_head;
    logic               w_full;
    logic               w_empty;
    logic [FIFO_LOG2:0] w_count;
    logic               w_dropped;
    logic [31:0]        w_word;
    logic               w_unused;

    assign w_unused = ^{modify[2], wdata[31], wdata[28:0], w_full};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Stop-bit decision is taken at the last tick of the stop bit.
    assign w_stop_tick = (r_state == ST_STOP) && (r_cnt == CNT_LAST);
    assign w_push      = w_stop_tick &  r_rx_sync;
    assign w_ferr_set  = w_stop_tick & ~r_rx_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= r_rx_sync ? ST_IDLE : ST_BREAK;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (r_rx_sync) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_modify = (modify[1:0] != MOD_NONE);
    assign w_req    = (read | w_modify) & (addr == CSR_ADDR);
    assign w_pop    = w_req & read;
    assign w_clr    = w_req & w_modify;

    byte_fifo #(
        .FIFO_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_dropped   (w_dropped)
    );

    assign w_word = pack_status(w_empty, r_ovr, r_ferr, 5'(w_count), w_head);

    // Set beats clear: an error arriving during its own clear stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_ovr   <= (r_ovr  & ~(w_clr & wdata[CSR_BIT_OVR]))  | w_dropped;
            r_ferr  <= (r_ferr & ~(w_clr & wdata[CSR_BIT_FERR])) | w_ferr_set;
            r_valid <= w_req;
            r_rdata <= w_req ? w_word : 32'h0;
            r_irq   <= ~w_empty;
        end
    end

    assign rdata  = r_rdata;
    assign valid  = r_valid;
    assign irq_rx = r_irq;

endmodule
